audio_adc_deserializer: RTL

AUDIO_ADC_DESERIALIZER -- requirements
Module: audio_adc_deserializer

---
 rtl/audio_pkg.sv | 17 +
 rtl/audio_in_fifo.sv | 70 +++++++
 rtl/audio_adc_deserializer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared constants and types for the audio ADC input path.
//   des_state_t    : deserializer state encoding
//   DEF_*          : default parameter values for the deserializer and FIFO
package audio_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_I2S_DELAY  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // waiting for the first LRCK fall after reset
        ST_SKIP  = 2'd1,   // discarding the I2S delay bits
        ST_SHIFT = 2'd2,   // capturing sample bits
        ST_HOLD  = 2'd3    // half complete, extra bits ignored
    } des_state_t;

endpackage

// File: rtl/audio_in_fifo.sv
// Show-ahead FIFO of stereo pairs.
//   clk, rst_n : clock, async active-low reset
//   clear      : synchronous flush + overflow clear (beats push/pop)
//   push/wdata : write request and data; dropped when full unless popping
//   pop        : advance head; ignored when empty
//   rdata      : head entry (0 when empty)
//   empty      : no entries stored
//   count      : entries stored
//   overflow   : sticky, a push was dropped because the FIFO was full
module audio_in_fifo
    import audio_pkg::*;
#(
    parameter int WIDTH = 2 * DEF_DATA_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             full, pop_ok, push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok && !clear)
            mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/audio_adc_deserializer.sv
// I2S ADC deserializer with stereo-pair FIFO.
//   CLOCK_50, reset          : system clock, async active-low reset
//   AUD_BCLK/ADCLRCK/ADCDAT  : codec serial interface (asynchronous)
//   clear_audio_in_memory    : flush FIFO, clear overflow
//   read_audio_in            : pop head pair
//   audio_in_available       : FIFO non-empty
//   left/right_channel_audio_in : head pair (show-ahead)
//   fifo_count, overflow     : FIFO occupancy and sticky drop flag
module audio_adc_deserializer
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int I2S_DELAY  = DEF_I2S_DELAY
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          AUD_BCLK,
    input  logic                          AUD_ADCLRCK,
    input  logic                          AUD_ADCDAT,
    input  logic                          clear_audio_in_memory,
    input  logic                          read_audio_in,
    output logic                          audio_in_available,
    output logic [DATA_WIDTH-1:0]         left_channel_audio_in,
    output logic [DATA_WIDTH-1:0]         right_channel_audio_in,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int CW  = $clog2(DATA_WIDTH + 1);
    localparam int SKW = $clog2(I2S_DELAY + 1) + 1;
    localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [SKW-1:0] SKIP_N   = SKW'(I2S_DELAY);

    // Synchronizers plus one extra flop each on BCLK/LRCK for edge detect.
    logic [1:0] bclk_sync, lrck_sync, dat_sync;
    logic       bclk_q, lrck_q;
    logic       bclk_rise, lrck_rise, lrck_fall, lrck_edge, dat_s;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bclk_q    <= 1'b0;
            lrck_q    <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[0], AUD_BCLK};
            lrck_sync <= {lrck_sync[0], AUD_ADCLRCK};
            dat_sync  <= {dat_sync[0],  AUD_ADCDAT};
            bclk_q    <= bclk_sync[1];
            lrck_q    <= lrck_sync[1];
        end
    end

    assign bclk_rise = bclk_sync[1] & ~bclk_q;
    assign lrck_rise = lrck_sync[1] & ~lrck_q;
    assign lrck_fall = ~lrck_sync[1] & lrck_q;
    assign lrck_edge = lrck_rise | lrck_fall;
    assign dat_s     = dat_sync[1];

    des_state_t             state, state_nx;
    logic [CW-1:0]          bit_cnt;
    logic [SKW-1:0]         skip_cnt;
    logic [DATA_WIDTH-1:0]  sh, left_q, just;
    logic [2*DATA_WIDTH-1:0] pair_q;
    logic                   half_q;     // 0 = left half in progress
    logic                   have_left;  // left half of this frame closed
    logic                   push_q;
    logic                   skip_done, restart, shift_en, skip_inc;
    logic                   close_left, close_pair;

    assign skip_done = (skip_cnt >= SKIP_N);
    // Short halves: move the captured bits to the top, zeros below.
    assign just = sh << (CW'(DATA_WIDTH) - bit_cnt);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (lrck_fall) state_nx = ST_SKIP;
            default: begin
                if (lrck_edge)     state_nx = ST_SKIP;
                else if (shift_en) state_nx = (bit_cnt == LAST_BIT) ? ST_HOLD : ST_SHIFT;
            end
        endcase
    end

    // The MSB is captured on the first BCLK rise after the delay bits,
    // while still in SKIP, so a zero delay needs no special case.
    always_comb begin
        restart    = (state == ST_IDLE) ? lrck_fall : lrck_edge;
        shift_en   = bclk_rise & ~lrck_edge &
                     ((state == ST_SHIFT) | ((state == ST_SKIP) & skip_done));
        skip_inc   = bclk_rise & ~lrck_edge & (state == ST_SKIP) & ~skip_done;
        close_left = (state != ST_IDLE) & lrck_rise & ~half_q;
        close_pair = (state != ST_IDLE) & lrck_fall & half_q & have_left;
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            bit_cnt   <= '0;
            skip_cnt  <= '0;
            sh        <= '0;
            left_q    <= '0;
            pair_q    <= '0;
            half_q    <= 1'b0;
            have_left <= 1'b0;
            push_q    <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (restart) begin
                bit_cnt   <= '0;
                skip_cnt  <= '0;
                sh        <= '0;
                half_q    <= lrck_sync[1];
                // Leaving IDLE also lands here with have_left cleared,
                // so a partial frame before the first fall is never paired.
                have_left <= close_left;
                if (close_left) left_q <= just;
                if (close_pair) begin
                    push_q <= 1'b1;
                    pair_q <= {left_q, just};
                end
            end else if (shift_en) begin
                sh      <= {sh[DATA_WIDTH-2:0], dat_s};
                bit_cnt <= bit_cnt + CW'(1);
            end else if (skip_inc) begin
                skip_cnt <= skip_cnt + SKW'(1);
            end
        end
    end

    logic                    fifo_empty;
    logic [2*DATA_WIDTH-1:0] head;

    audio_in_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLOCK_50),
        .rst_n    (reset),
        .clear    (clear_audio_in_memory),
        .push     (push_q),
        .wdata    (pair_q),
        .pop      (read_audio_in),
        .rdata    (head),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .overflow (overflow)
    );

    assign audio_in_available     = ~fifo_empty;
    assign left_channel_audio_in  = head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign right_channel_audio_in = head[DATA_WIDTH-1:0];

endmodule
